cpu_control_fsm: RTL and testbench

Instruction-sequencing controller for the 8-bit CPU. It drives the program counter's `increment`/`jumper`/`jumper_d` inputs and the memory read strobe. It fetches opcode and operand bytes over a ready-handshake, decodes a 4-bit opcode and issues one-cycle execute controls to the ALU/accumulator. It sits between the program counter, instruction memory and ALU, and is the only source of PC control.

---
 rtl/cpu_control_fsm.sv | 132 +++++++++++++
 tb/tb_cpu_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm
//   Instruction-sequencing controller for the 8-bit CPU. Fetches an opcode
//   byte, and an operand byte for two-byte instructions, over a ready
//   handshake. It decodes the 4-bit opcode in ir[7:4] and issues one-cycle
//   execute strobes to the ALU/accumulator. It is the only source of
//   program-counter control.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   run          start request, sampled only in IDLE
//   mem_rdata    byte read from memory at the current PC
//   mem_ready    read completes this cycle (honoured only while mem_rd=1)
//   zero_flag    ALU zero flag, used only in EXEC
//   carry_flag   ALU carry flag, used only in EXEC
//   mem_rd       read strobe, high throughout FETCH and OPFETCH
//   pc_increment PC increment pulse, one per byte consumed
//   pc_jump      PC load pulse on a taken jump
//   pc_jump_addr PC load value, always the operand register
//   ir_out       instruction register
//   operand_out  operand register
//   alu_en       ALU strobe (EXEC of ADD/SUB)
//   alu_op       ir[7:4] while alu_en=1, else 0
//   acc_load     accumulator write strobe (EXEC of LDI/ADD/SUB)
//   halted       high in HALT
//   busy         high in every state except IDLE and HALT
module cpu_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  input  logic       zero_flag,
  input  logic       carry_flag,
  output logic       mem_rd,
  output logic       pc_increment,
  output logic       pc_jump,
  output logic [7:0] pc_jump_addr,
  output logic [7:0] ir_out,
  output logic [7:0] operand_out,
  output logic       alu_en,
  output logic [3:0] alu_op,
  output logic       acc_load,
  output logic       halted,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_OPFETCH = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [7:0] ir;
  logic [7:0] operand;
  logic [3:0] opcode;

  assign opcode = ir[7:4];

  // Opcodes 0x1..0x6 carry an operand byte; everything else is one byte.
  function automatic logic is_two_byte(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_JC);
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (run) state_next = S_FETCH;
      S_FETCH:   if (mem_ready) state_next = S_DECODE;
      S_DECODE:  state_next = is_two_byte(opcode) ? S_OPFETCH : S_EXEC;
      S_OPFETCH: if (mem_ready) state_next = S_EXEC;
      S_EXEC:    state_next = (opcode == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ir      <= 8'h00;
      operand <= 8'h00;
    end else begin
      state <= state_next;
      if (state == S_FETCH && mem_ready) ir <= mem_rdata;
      if (state == S_OPFETCH && mem_ready) operand <= mem_rdata;
    end
  end

  logic in_exec;
  logic jump_taken;

  assign in_exec = (state == S_EXEC);

  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = zero_flag;
      OP_JC:   jump_taken = carry_flag;
      default: jump_taken = 1'b0;
    endcase
  end

  assign mem_rd       = (state == S_FETCH) || (state == S_OPFETCH);
  // Mealy: the PC advances in the same cycle the byte is accepted.
  assign pc_increment = mem_rd && mem_ready;
  // Jumps exist only in EXEC where mem_rd is low, so they never overlap
  // an increment.
  assign pc_jump      = in_exec && jump_taken;
  assign pc_jump_addr = operand;
  assign ir_out       = ir;
  assign operand_out  = operand;
  assign alu_en       = in_exec && ((opcode == OP_ADD) || (opcode == OP_SUB));
  assign alu_op       = alu_en ? opcode : 4'h0;
  assign acc_load     = in_exec && ((opcode == OP_LDI) || (opcode == OP_ADD) ||
                                    (opcode == OP_SUB));
  assign halted       = (state == S_HALT);
  assign busy         = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_cpu_control_fsm.sv
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       zero_flag;
  logic       carry_flag;
  logic       mem_rd;
  logic       pc_increment;
  logic       pc_jump;
  logic [7:0] pc_jump_addr;
  logic [7:0] ir_out;
  logic [7:0] operand_out;
  logic       alu_en;
  logic [3:0] alu_op;
  logic       acc_load;
  logic       halted;
  logic       busy;

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .run(run), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .mem_rd(mem_rd), .pc_increment(pc_increment), .pc_jump(pc_jump),
    .pc_jump_addr(pc_jump_addr), .ir_out(ir_out), .operand_out(operand_out),
    .alu_en(alu_en), .alu_op(alu_op), .acc_load(acc_load),
    .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory / flag responder ----------------
  logic [7:0] prog [0:15];
  int  addr, wcnt, wait_cfg, cyc;
  bit  took, noise_en, ztoggle, zconst, cconst;

  always @(negedge clk) took = mem_rd && mem_ready;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (took) begin
      addr++;
      wcnt = 0;
    end
    if (mem_rd) begin
      if (wcnt < wait_cfg) begin
        mem_ready = 1'b0;
        wcnt++;
      end else begin
        mem_ready = 1'b1;
      end
    end else begin
      mem_ready = noise_en ? ($urandom_range(0, 1) != 0) : 1'b0;
    end
    mem_rdata  = prog[addr[3:0]];
    zero_flag  = ztoggle ? (cyc != 4) : zconst;
    carry_flag = cconst;
  end

  // ---------------- behavioural model ----------------
  // Tracks how many bytes of the current instruction have arrived and
  // whether the opcode has been looked at yet; the outputs follow from that.
  logic       m_active, m_halt;
  logic [7:0] m_ir, m_opnd;
  int         m_got;
  bit         m_dec;

  localparam int PH_IDLE = 0, PH_READ = 1, PH_LOOK = 2, PH_DO = 3, PH_STOP = 4;

  function automatic int phase();
    if (!m_active) return m_halt ? PH_STOP : PH_IDLE;
    if (m_got == 0) return PH_READ;
    if (m_got == 1 && !m_dec) return PH_LOOK;
    if (m_got == 1 && m_ir[7:4] >= 4'h1 && m_ir[7:4] <= 4'h6) return PH_READ;
    return PH_DO;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0; m_halt <= 1'b0; m_ir <= 8'h00; m_opnd <= 8'h00;
      m_got <= 0; m_dec <= 1'b0;
    end else begin
      case (phase())
        PH_IDLE: if (run) begin m_active <= 1'b1; m_got <= 0; m_dec <= 1'b0; end
        PH_READ: if (mem_ready) begin
          if (m_got == 0) begin m_ir <= mem_rdata; m_got <= 1; m_dec <= 1'b0; end
          else begin m_opnd <= mem_rdata; m_got <= 2; end
        end
        PH_LOOK: m_dec <= 1'b1;
        PH_DO: begin
          if (m_ir[7:4] == 4'hF) begin m_active <= 1'b0; m_halt <= 1'b1; end
          else begin m_got <= 0; m_dec <= 1'b0; end
        end
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare and event counters ----------------
  int inc_cnt, jmp_cnt, alu_cnt, rd_cnt, acc_cyc, inc_at_acc;
  logic [7:0] last_jaddr, ir_at_acc, op_at_acc;
  logic [3:0] aluop_first;
  logic       acc_at_alu;

  always @(negedge clk) begin
    int ph;
    logic [3:0] op;
    logic e_rd, e_do, e_jmp, e_alu, e_acc;
    ph    = phase();
    op    = m_ir[7:4];
    e_rd  = (ph == PH_READ);
    e_do  = (ph == PH_DO);
    e_jmp = e_do && (op == 4'h4 || (op == 4'h5 && zero_flag) || (op == 4'h6 && carry_flag));
    e_alu = e_do && (op == 4'h2 || op == 4'h3);
    e_acc = e_do && (op >= 4'h1 && op <= 4'h3);
    chk("mem_rd", {7'd0, mem_rd}, {7'd0, e_rd});
    chk("pc_increment", {7'd0, pc_increment}, {7'd0, e_rd && mem_ready});
    chk("pc_jump", {7'd0, pc_jump}, {7'd0, e_jmp});
    chk("pc_jump_addr", pc_jump_addr, m_opnd);
    chk("ir_out", ir_out, m_ir);
    chk("operand_out", operand_out, m_opnd);
    chk("alu_en", {7'd0, alu_en}, {7'd0, e_alu});
    chk("alu_op", {4'd0, alu_op}, e_alu ? {4'd0, op} : 8'h00);
    chk("acc_load", {7'd0, acc_load}, {7'd0, e_acc});
    chk("halted", {7'd0, halted}, {7'd0, m_halt});
    chk("busy", {7'd0, busy}, {7'd0, m_active});
    chk("inc_jump_excl", {7'd0, pc_increment && pc_jump}, 8'h00);

    if (pc_increment) inc_cnt++;
    if (mem_rd) rd_cnt++;
    if (pc_jump) begin jmp_cnt++; last_jaddr = pc_jump_addr; end
    if (alu_en) begin
      if (alu_cnt == 0) begin aluop_first = alu_op; acc_at_alu = acc_load; end
      alu_cnt++;
    end
    if (acc_load && acc_cyc < 0) begin
      acc_cyc = cyc; inc_at_acc = inc_cnt; ir_at_acc = ir_out; op_at_acc = operand_out;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_counts();
    inc_cnt = 0; jmp_cnt = 0; alu_cnt = 0; rd_cnt = 0; acc_cyc = -1; inc_at_acc = 0;
    last_jaddr = 8'h00; ir_at_acc = 8'h00; op_at_acc = 8'h00;
    aluop_first = 4'h0; acc_at_alu = 1'b0;
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = b0; prog[1] = b1; prog[2] = b2; prog[3] = b3; prog[4] = b4; prog[5] = b5;
  endtask

  task automatic do_reset(input int wc);
    reset = 1'b0; run = 1'b0; wait_cfg = wc; addr = 0; wcnt = 0;
    ztoggle = 1'b0; zconst = 1'b0; cconst = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic start();
    @(posedge clk);
    #2;
    run = 1'b1;
    cyc = 0;
    clear_counts();
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; mem_rdata = 8'h00; mem_ready = 1'b0;
    zero_flag = 1'b0; carry_flag = 1'b0; noise_en = 1'b1;
    addr = 0; wcnt = 0; wait_cfg = 0; cyc = 0; took = 1'b0;
    ztoggle = 1'b0; zconst = 1'b0; cconst = 1'b0;
    load_prog(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    clear_counts();

    // Reset held: run and mem_ready toggling must not move anything.
    repeat (4) begin
      @(posedge clk);
      #2 run = ~run;
    end
    #1;
    chk("rst_mem_rd", {7'd0, mem_rd}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'h00);
    chk("rst_jaddr", pc_jump_addr, 8'h00);

    // Asynchronous reset in the middle of a waited fetch.
    load_prog(8'h10, 8'h2A, 8'hF0, 8'h00, 8'h00, 8'h00);
    do_reset(3);
    start();
    @(posedge clk);
    #3;
    chk("midfetch_rd", {7'd0, mem_rd}, 8'h01);
    reset = 1'b0;
    #1;
    chk("async_mem_rd", {7'd0, mem_rd}, 8'h00);
    chk("async_busy", {7'd0, busy}, 8'h00);
    chk("async_inc", {7'd0, pc_increment}, 8'h00);

    // NOP stream: one increment every 3 cycles, never a jump.
    load_prog(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset(0);
    start();
    repeat (30) @(posedge clk);
    #1;
    chk_int("nop_incs", inc_cnt, 10);
    chk_int("nop_jumps", jmp_cnt, 0);

    // LDI 0x2A with two wait cycles on each read.
    load_prog(8'h10, 8'h2A, 8'hF0, 8'h00, 8'h00, 8'h00);
    do_reset(2);
    start();
    repeat (18) @(posedge clk);
    #1;
    chk_int("ldi_acc_cycle", acc_cyc, 8);
    chk_int("ldi_incs", inc_at_acc, 2);
    chk("ldi_ir", ir_at_acc, 8'h10);
    chk("ldi_operand", op_at_acc, 8'h2A);
    chk("ldi_halted", {7'd0, halted}, 8'h01);

    // JZ 0x80 with zero set, clear, and toggling except in EXEC.
    for (int mode = 0; mode < 3; mode++) begin
      load_prog(8'h50, 8'h80, 8'hF0, 8'h00, 8'h00, 8'h00);
      do_reset(0);
      zconst  = (mode == 0);
      ztoggle = (mode == 2);
      start();
      repeat (10) @(posedge clk);
      #1;
      if (mode == 0) begin
        chk_int("jz_taken", jmp_cnt, 1);
        chk("jz_addr", last_jaddr, 8'h80);
      end else begin
        chk_int("jz_not_taken", jmp_cnt, 0);
      end
    end

    // JMP 0x77 then JC 0x33 with carry set.
    load_prog(8'h40, 8'h77, 8'h60, 8'h33, 8'hF0, 8'h00);
    do_reset(1);
    cconst = 1'b1;
    start();
    repeat (20) @(posedge clk);
    #1;
    chk_int("jmp_jc_count", jmp_cnt, 2);
    chk("jc_addr", last_jaddr, 8'h33);

    // ADD 0x05, a one-byte NOP-class opcode, SUB 0x01.
    load_prog(8'h23, 8'h05, 8'h95, 8'h33, 8'h01, 8'hF0);
    do_reset(0);
    start();
    repeat (16) @(posedge clk);
    #1;
    chk_int("add_sub_alu_count", alu_cnt, 2);
    chk("add_alu_op", {4'd0, aluop_first}, 8'h02);
    chk("add_acc_load", {7'd0, acc_at_alu}, 8'h01);

    // HLT: absorbing with run held high, left only through reset.
    load_prog(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset(0);
    start();
    repeat (6) @(posedge clk);
    #2;
    rd_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk_int("hlt_no_reads", rd_cnt, 0);
    chk("hlt_halted", {7'd0, halted}, 8'h01);
    chk("hlt_busy", {7'd0, busy}, 8'h00);
    #2 reset = 1'b0;
    #1;
    chk("hlt_reset_halted", {7'd0, halted}, 8'h00);
    run = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", {7'd0, busy}, 8'h00);
    chk("idle_halted", {7'd0, halted}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
